// File: rtl/logic_op_pkg.sv
// Shared types for the logic_op_pipe datapath: operation encoding and its width.
package logic_op_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOTA = 3'd6,
    OP_ACC  = 3'd7
  } op_e;

endpackage

// File: rtl/logic_op_alu.sv
// Combinational bitwise logic unit; OP_ACC folds operand A into the supplied accumulator base.
module logic_op_alu
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  op_e              op_i,
  input  logic [WIDTH-1:0] acc_base_i,
  output logic [WIDTH-1:0] result_o
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves result_o unassigned (no latch).
    result_o = '0;
    case (op_i)
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NAND: result_o = ~(a_i & b_i);
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_NOTA: result_o = ~a_i;
      OP_ACC:  result_o = acc_base_i ^ a_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_op_pipe.sv
// Two-stage valid/ready bitwise logic pipeline with XOR accumulator.
// Define LOGIC_OP_FLAGS_EN to add registered out_zero/out_parity result flags.
module logic_op_pipe
  import logic_op_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inp_1,
  input  logic [WIDTH-1:0] inp_2,
  input  logic [OP_W-1:0]  op_cntrl,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef LOGIC_OP_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_parity
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  op_e              s1_op_q, s1_op_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             s1_adv;
  logic             accept;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] alu_res;

  assign s1_adv   = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept   = in_valid && in_ready;
  // A clear in the same cycle as an accumulate takes effect before the XOR.
  assign acc_base = acc_clr ? ACC_INIT : acc_q;

  logic_op_alu #(.WIDTH(WIDTH)) u_alu (
    .a_i        (s1_a_q),
    .b_i        (s1_b_q),
    .op_i       (s1_op_q),
    .acc_base_i (acc_base),
    .result_o   (alu_res)
  );

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_op_d     = s1_op_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    acc_d       = acc_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_a_d     = inp_1;
      s1_b_d     = inp_2;
      s1_op_d    = op_e'(op_cntrl);
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      out_valid_d = 1'b1;
      out_d       = alu_res;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (s1_adv && (s1_op_q == OP_ACC)) begin
      acc_d = alu_res;
    end else if (acc_clr) begin
      acc_d = ACC_INIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= OP_AND;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      acc_q       <= ACC_INIT;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;

`ifdef LOGIC_OP_FLAGS_EN
  logic zero_q, parity_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_q   <= 1'b1;
      parity_q <= 1'b0;
    end else if (s1_adv) begin
      zero_q   <= ~|alu_res;
      parity_q <= ^alu_res;
    end
  end

  assign out_zero   = zero_q;
  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_logic_op_pipe.sv
// Self-checking bench for logic_op_pipe: spec vector table, accumulator/backpressure/reset
// sequences, then randomized traffic against a transaction-level reference model.
module tb_logic_op_pipe;
  import logic_op_pkg::*;

  localparam int               W  = 8;
  localparam logic [W-1:0]     AI = 8'h00;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, acc_clr, out_valid, out_ready;
  logic [W-1:0] inp_1, inp_2, out;
  logic [2:0]   op_cntrl;
`ifdef LOGIC_OP_FLAGS_EN
  logic         out_zero, out_parity;
`endif

  logic_op_pipe #(.WIDTH(W), .ACC_INIT(AI)) dut (
    .clk       (clk),
    .reset     (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inp_1     (inp_1),
    .inp_2     (inp_2),
    .op_cntrl  (op_cntrl),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef LOGIC_OP_FLAGS_EN
    ,
    .out_zero  (out_zero),
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level model: commands complete in accept order, so the accumulator
  // can be folded at accept time; results wait in a FIFO until the consumer takes them.
  typedef struct {
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_acc;
  int           cyc_n    = 0;
  bit           chk_lat  = 1'b0;
  bit           prev_hold = 1'b0;
  logic [W-1:0] prev_out;
  bit           acc_last;

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b, input logic [W-1:0] acc);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return acc ^ a;
    endcase
  endfunction

  task automatic cycle(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input bit clr, input bit ordy,
                       input bit use_exp, input logic [W-1:0] exp_v);
    exp_t         e;
    logic [W-1:0] r;
    @(negedge clk);
    in_valid  = v;
    inp_1     = a;
    inp_2     = b;
    op_cntrl  = op;
    acc_clr   = clr;
    out_ready = ordy;
    #1;
    cyc_n++;
    if (prev_hold) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_data", 64'(out), 64'(prev_out));
    end
    if (out_valid && ordy) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("out_data", 64'(out), 64'(e.data));
        if (chk_lat) check("latency", 64'(cyc_n - e.cyc), 64'd2);
`ifdef LOGIC_OP_FLAGS_EN
        check("out_zero", 64'(out_zero), 64'(e.data == '0));
        check("out_parity", 64'(out_parity), 64'(^e.data));
`endif
      end
    end
    acc_last = v && in_ready;
    if (acc_last) begin
      r = use_exp ? exp_v : ref_op(op, a, b, m_acc);
      if (op == 3'd7) m_acc = r;
      sb.push_back('{data: r, cyc: cyc_n});
    end
    prev_hold = out_valid && !ordy;
    prev_out  = out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, 1'b0, '0);
  endtask

  task automatic cmd(input logic [W-1:0] a, input logic [2:0] op, input logic [W-1:0] exp_v);
    cycle(1'b1, a, '0, op, 1'b0, 1'b1, 1'b1, exp_v);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t tbl[12];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } cmd_t;

  cmd_t bp[4];

  initial begin
    int idx;
    tbl[0]  = '{3'd0, 8'hF0, 8'h3C, 8'h30};
    tbl[1]  = '{3'd1, 8'hF0, 8'h3C, 8'hFC};
    tbl[2]  = '{3'd2, 8'hF0, 8'h3C, 8'hCC};
    tbl[3]  = '{3'd3, 8'hF0, 8'h3C, 8'hCF};
    tbl[4]  = '{3'd4, 8'hF0, 8'h3C, 8'h03};
    tbl[5]  = '{3'd5, 8'hF0, 8'h3C, 8'h33};
    tbl[6]  = '{3'd6, 8'hF0, 8'h3C, 8'h0F};
    tbl[7]  = '{3'd0, 8'hF0, 8'h0F, 8'h00};
    tbl[8]  = '{3'd2, 8'h07, 8'h00, 8'h07};
    tbl[9]  = '{3'd7, 8'h0F, 8'hA5, 8'h0F};
    tbl[10] = '{3'd7, 8'hF0, 8'h5A, 8'hFF};
    tbl[11] = '{3'd7, 8'hFF, 8'h00, 8'h00};
    bp[0] = '{3'd7, 8'h33, 8'h00};
    bp[1] = '{3'd0, 8'hF0, 8'h3C};
    bp[2] = '{3'd1, 8'h81, 8'h18};
    bp[3] = '{3'd2, 8'hAA, 8'h0F};

    rst = 1'b1; in_valid = 1'b0; inp_1 = '0; inp_2 = '0; op_cntrl = '0;
    acc_clr = 1'b0; out_ready = 1'b1;
    m_acc = AI;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
`ifdef LOGIC_OP_FLAGS_EN
    check("rst_zero", 64'(out_zero), 64'd1);
    check("rst_parity", 64'(out_parity), 64'd0);
`endif
    @(negedge clk); rst = 1'b0; #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Spec vectors back-to-back with the consumer always ready.
    chk_lat = 1'b1;
    foreach (tbl[i]) cycle(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 1'b0, 1'b1, 1'b1, tbl[i].exp);
    idle(3);
    check("tbl_drained", 64'(sb.size()), 64'd0);

    // Stand-alone clear, then accumulate from the init value.
    cycle(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 1'b0, '0);
    m_acc = AI;
    idle(1);
    cmd(8'h55, 3'd7, 8'h55);
    idle(3);
    cmd(8'hFF, 3'd7, 8'hAA);
    idle(3);
    // Clear coincides with the accumulate advancing out of S1: clear wins first.
    cmd(8'h01, 3'd7, 8'h01);
    cycle(1'b0, '0, '0, 3'd0, 1'b1, 1'b1, 1'b0, '0);
    idle(3);
    cmd(8'h00, 3'd7, 8'h01);
    idle(3);
    check("acc_drained", 64'(sb.size()), 64'd0);

    // Backpressure: consumer stalled for 5 cycles while 4 commands are offered.
    chk_lat = 1'b0;
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, bp[idx].a, bp[idx].b, bp[idx].op, 1'b0, 1'b0, 1'b0, '0);
      if (acc_last) idx++;
    end
    check("bp_accepts", 64'(idx), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    if (sb.size() > 0) check("bp_out_first", 64'(out), 64'(sb[0].data));
    for (int k = 0; k < 20 && (idx < 4 || sb.size() != 0); k++) begin
      if (idx < 4) begin
        cycle(1'b1, bp[idx].a, bp[idx].b, bp[idx].op, 1'b0, 1'b1, 1'b0, '0);
        if (acc_last) idx++;
      end else begin
        idle(1);
      end
    end
    check("bp_all_accepted", 64'(idx), 64'd4);
    check("bp_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset with both stages full.
    cycle(1'b1, 8'h5A, 8'h00, 3'd7, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b1, 8'h12, 8'h34, 3'd1, 1'b0, 1'b0, 1'b0, '0);
    cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b0, 1'b0, '0);
    check("full_out_valid", 64'(out_valid), 64'd1);
    check("full_in_ready", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out", 64'(out), 64'd0);
`ifdef LOGIC_OP_FLAGS_EN
    check("arst_zero", 64'(out_zero), 64'd1);
`endif
    sb.delete();
    m_acc     = AI;
    prev_hold = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    check("arst_in_ready", 64'(in_ready), 64'd1);
    chk_lat = 1'b1;
    cmd(8'h11, 3'd7, 8'h11);
    idle(3);
    check("arst_drained", 64'(sb.size()), 64'd0);

    // Randomized traffic with random consumer stalls.
    chk_lat = 1'b0;
    for (int k = 0; k < 400; k++) begin
      cycle(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 3'($urandom_range(0, 7)),
            1'b0, ($urandom_range(0, 9) < 7), 1'b0, '0);
    end
    for (int k = 0; k < 10 && sb.size() != 0; k++) idle(1);
    check("rand_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
